// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared parameter defaults and state encoding for the shift-and-add multiplier and its paired alu.
package shift_add_mult_ctrl_pkg;

  localparam int unsigned MULT_MBITS = 12;
  localparam int unsigned MULT_CBITS = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_mult_ctrl_fsm.sv
// Control FSM for the shift-and-add multiplier: state, iteration count, busy and done.
module mult_ctrl_fsm
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter int unsigned MBITS = MULT_MBITS,
  parameter int unsigned CBITS = MULT_CBITS
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  output state_t state,
  output logic   busy,
  output logic   done,
  output logic   load_c,
  output logic   last_c
);

  state_t           state_nx;
  logic [CBITS-1:0] count;
  logic [CBITS-1:0] count_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      busy  <= (state_nx != S_IDLE);
      done  <= (state_nx == S_DONE);
    end
  end

  // start is only honoured in IDLE, so pulses during RUN or DONE are dropped
  always_comb begin
    state_nx = state;
    count_nx = count;
    load_c   = 1'b0;
    last_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load_c   = 1'b1;
          count_nx = '0;
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        count_nx = count + CBITS'(1);
        if (count == CBITS'(MBITS - 1)) begin
          last_c   = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Shift-and-add multiplier datapath driving an external alu adder.
// Define MULT_SIGNED_EN for two's-complement operands via radix-2 Booth recoding.
module shift_add_mult_ctrl
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter int unsigned MBITS = MULT_MBITS,
  parameter int unsigned CBITS = MULT_CBITS,
  parameter int unsigned ABITS = MBITS + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [MBITS-1:0]     a_in,
  input  logic [MBITS-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*MBITS-1:0]   product,
  output logic [ABITS-1:0]     alu_a,
  output logic [ABITS-1:0]     alu_b,
  output logic                 alu_cin,
  input  logic [ABITS-1:0]     alu_out
);

  state_t           state;
  logic             load_c;
  logic             last_c;
  logic [ABITS-1:0] acc;
  logic [MBITS-1:0] q;
  logic [MBITS-1:0] m;
  logic [ABITS-1:0] acc_nx;
  logic [MBITS-1:0] q_nx;
`ifdef MULT_SIGNED_EN
  logic             q_m1;
`endif

  mult_ctrl_fsm #(
    .MBITS (MBITS),
    .CBITS (CBITS)
  ) u_fsm (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .state  (state),
    .busy   (busy),
    .done   (done),
    .load_c (load_c),
    .last_c (last_c)
  );

  // addend selection; the adder is driven only while iterating
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    if (state == S_RUN) begin
      alu_a = acc;
`ifdef MULT_SIGNED_EN
      case ({q[0], q_m1})
        2'b01: alu_b = {m[MBITS-1], m};
        2'b10: begin
          alu_b   = ~{m[MBITS-1], m};
          alu_cin = 1'b1;
        end
        default: alu_b = '0;
      endcase
`else
      if (q[0]) alu_b = {1'b0, m};
`endif
    end
  end

  // one-bit right shift of {sum, Q}; the sign (or zero) fills the top of A
  always_comb begin
`ifdef MULT_SIGNED_EN
    acc_nx = {alu_out[ABITS-1], alu_out[ABITS-1:1]};
`else
    acc_nx = {1'b0, alu_out[ABITS-1:1]};
`endif
    q_nx = {alu_out[0], q[MBITS-1:1]};
  end

  // product is written on the final iteration so it is valid alongside done
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      product <= '0;
`ifdef MULT_SIGNED_EN
      q_m1    <= 1'b0;
`endif
    end else if (load_c) begin
      acc     <= '0;
      q       <= b_in;
      m       <= a_in;
`ifdef MULT_SIGNED_EN
      q_m1    <= 1'b0;
`endif
    end else if (state == S_RUN) begin
      acc <= acc_nx;
      q   <= q_nx;
`ifdef MULT_SIGNED_EN
      q_m1 <= q[0];
`endif
      if (last_c) product <= {acc_nx[MBITS-1:0], q_nx};
    end
  end

endmodule
